// File: rtl/bp_be_pkg.sv
// Shared back-end types: processor config lookup and the loop-inference scheduler
// state and response types.
package bp_be_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

  // The response struct is sized for the default configuration (4 requesters, 8-bit estimate).
  localparam int unsigned bp_be_loop_sched_id_width_gp   = 2;
  localparam int unsigned bp_be_loop_sched_iter_width_gp = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StDiscover,
    StConfirmed,
    StResp
  } bp_be_loop_sched_state_e;

  typedef struct packed {
    logic [bp_be_loop_sched_id_width_gp-1:0]   id;
    logic [bp_be_loop_sched_iter_width_gp-1:0] iter;
    logic                                      timeout;
  } bp_be_loop_sched_resp_s;

  function automatic int unsigned bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: the requester closest at or after the priority pointer wins;
// the pointer moves past the winner when the grant is taken.
module bsg_arb_round_robin #(
  parameter int unsigned width_p = 4,
  localparam int unsigned id_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [width_p-1:0]     reqs_i,
  input  logic                   yumi_i,
  output logic                   v_o,
  output logic [width_p-1:0]     grants_o,
  output logic [id_width_lp-1:0] id_o
);

  logic [id_width_lp-1:0] r_ptr;
  int unsigned            w_idx;

  // Walk from the farthest offset down so the nearest requester is the last one assigned.
  always_comb begin
    v_o      = 1'b0;
    grants_o = '0;
    id_o     = '0;
    w_idx    = 0;
    for (int i = int'(width_p) - 1; i >= 0; i--) begin
      w_idx = (int'(r_ptr) + i) % width_p;
      if (reqs_i[w_idx]) begin
        v_o             = 1'b1;
        id_o            = id_width_lp'(w_idx);
        grants_o        = '0;
        grants_o[w_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ptr <= '0;
    end else if (yumi_i && v_o) begin
      r_ptr <= (id_o == id_width_lp'(width_p - 1)) ? '0 : id_o + id_width_lp'(1);
    end
  end

endmodule

// File: rtl/bp_be_loop_inference_sched.sv
// Shares one loop-inference unit among several striding-load detector entries:
// arbitrates, sequences start/confirm/result, and returns a tagged iteration estimate.
module bp_be_loop_inference_sched
  import bp_be_pkg::*;
#(
  parameter bp_params_e  bp_params_p    = e_bp_default_cfg,
  parameter int unsigned num_req_p      = 4,
  parameter int unsigned timeout_p      = 1024,
  parameter int unsigned output_range_p = 8,
  parameter int unsigned default_iter_p = 128,
  localparam int unsigned vaddr_width_p = bp_vaddr_width(bp_params_p),
  localparam int unsigned id_width_lp   = $clog2(num_req_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p*vaddr_width_p-1:0] req_pc_i,
  input  logic [num_req_p-1:0]               req_confirm_i,
  output logic [num_req_p-1:0]               grant_o,
  output logic                               start_discovery_o,
  output logic                               confirm_discovery_o,
  output logic [vaddr_width_p-1:0]           striding_pc_o,
  input  logic [output_range_p-1:0]          inf_iter_i,
  input  logic                               inf_v_i,
  output logic                               inf_yumi_o,
  output logic                               resp_v_o,
  output logic [id_width_lp-1:0]             resp_id_o,
  output logic [output_range_p-1:0]          resp_iter_o,
  output logic                               resp_timeout_o,
  input  logic                               resp_ready_i
);

  localparam int unsigned cnt_width_lp = $clog2(timeout_p);
  localparam logic [cnt_width_lp-1:0]   timeout_last_lp  = cnt_width_lp'(timeout_p - 1);
  localparam logic [output_range_p-1:0] default_iter_lp  = output_range_p'(default_iter_p);

  bp_be_loop_sched_state_e    r_state;
  bp_be_loop_sched_resp_s     r_resp;
  logic [id_width_lp-1:0]     r_id;
  logic [vaddr_width_p-1:0]   r_pc;
  logic [cnt_width_lp-1:0]    r_cnt;
  logic                       r_start;
  logic                       r_confirm;
  logic                       r_resp_v;
  // Held low through reset so the combinational grant/yumi outputs read 0 until the first edge.
  logic                       r_active;

  logic                       w_arb_v;
  logic [num_req_p-1:0]       w_arb_grants;
  logic [id_width_lp-1:0]     w_arb_id;
  logic                       w_grant;
  logic                       w_capture;
  logic                       w_my_confirm;
  logic                       w_timeout;
  logic [vaddr_width_p-1:0]   w_win_pc;

  bsg_arb_round_robin #(
    .width_p (num_req_p)
  ) u_arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .reqs_i    (req_v_i),
    .yumi_i    (w_grant),
    .v_o       (w_arb_v),
    .grants_o  (w_arb_grants),
    .id_o      (w_arb_id)
  );

  assign w_grant      = r_active && (r_state == StIdle) && w_arb_v;
  assign w_win_pc     = req_pc_i[int'(w_arb_id)*vaddr_width_p +: vaddr_width_p];
  assign w_my_confirm = req_confirm_i[r_id];
  assign w_timeout    = (r_cnt == timeout_last_lp);
  // Results are always consumed; only those arriving during discovery are kept.
  assign w_capture    = inf_yumi_o && ((r_state == StDiscover) || (r_state == StConfirmed));

  assign grant_o             = w_grant ? w_arb_grants : '0;
  assign inf_yumi_o          = r_active && inf_v_i;
  assign start_discovery_o   = r_start;
  assign confirm_discovery_o = r_confirm;
  assign striding_pc_o       = r_pc;
  assign resp_v_o            = r_resp_v;
  assign resp_id_o           = r_resp.id;
  assign resp_iter_o         = r_resp.iter;
  assign resp_timeout_o      = r_resp.timeout;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= StIdle;
      r_resp    <= '0;
      r_id      <= '0;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_confirm <= 1'b0;
      r_resp_v  <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_active <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_id    <= w_arb_id;
            r_pc    <= w_win_pc;
            r_start <= 1'b1;
            r_state <= StStart;
          end
        end
        StStart: begin
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= StDiscover;
        end
        StDiscover: begin
          // A measured result beats a confirm, and a confirm beats the timeout.
          if (w_capture) begin
            r_resp   <= '{id: r_id, iter: inf_iter_i, timeout: 1'b0};
            r_resp_v <= 1'b1;
            r_state  <= StResp;
          end else if (w_my_confirm) begin
            r_confirm <= 1'b1;
            r_state   <= StConfirmed;
          end else if (w_timeout) begin
            r_resp   <= '{id: r_id, iter: default_iter_lp, timeout: 1'b1};
            r_resp_v <= 1'b1;
            r_state  <= StResp;
          end else begin
            r_cnt <= r_cnt + cnt_width_lp'(1);
          end
        end
        StConfirmed: begin
          if (w_capture) begin
            r_resp    <= '{id: r_id, iter: inf_iter_i, timeout: 1'b0};
            r_resp_v  <= 1'b1;
            r_confirm <= 1'b0;
            r_state   <= StResp;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            r_resp_v <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(grant_o));
  a_start_pulse: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    start_discovery_o |=> !start_discovery_o);
  a_resp_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (resp_v_o && !resp_ready_i) |=> (resp_v_o && $stable(r_resp)));

endmodule

// File: tb/tb_bp_be_loop_inference_sched.sv
// Directed and randomized bench for the loop-inference scheduler, checked against a
// transaction-level model (round-robin pick plus per-discovery outcome rules).
module tb_bp_be_loop_inference_sched;

  localparam int VA      = 39;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 1024;
  localparam int DEFITER = 128;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_v;
  logic [NREQ*VA-1:0] req_pc;
  logic [NREQ-1:0]   req_confirm;
  logic [NREQ-1:0]   grant_o;
  logic              start_discovery_o;
  logic              confirm_discovery_o;
  logic [VA-1:0]     striding_pc_o;
  logic [7:0]        inf_iter;
  logic              inf_v;
  logic              inf_yumi_o;
  logic              resp_v_o;
  logic [1:0]        resp_id_o;
  logic [7:0]        resp_iter_o;
  logic              resp_timeout_o;
  logic              resp_ready;

  int n_chk = 0;
  int n_err = 0;
  int m_ptr = 0;
  logic [VA-1:0] exp_pc;

  always #5 clk = ~clk;

  bp_be_loop_inference_sched dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .req_v_i             (req_v),
    .req_pc_i            (req_pc),
    .req_confirm_i       (req_confirm),
    .grant_o             (grant_o),
    .start_discovery_o   (start_discovery_o),
    .confirm_discovery_o (confirm_discovery_o),
    .striding_pc_o       (striding_pc_o),
    .inf_iter_i          (inf_iter),
    .inf_v_i             (inf_v),
    .inf_yumi_o          (inf_yumi_o),
    .resp_v_o            (resp_v_o),
    .resp_id_o           (resp_id_o),
    .resp_iter_o         (resp_iter_o),
    .resp_timeout_o      (resp_timeout_o),
    .resp_ready_i        (resp_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant_o), 0);
    chk({tag, "_start"}, 64'(start_discovery_o), 0);
    chk({tag, "_confirm"}, 64'(confirm_discovery_o), 0);
    chk({tag, "_pc"}, 64'(striding_pc_o), 0);
    chk({tag, "_yumi"}, 64'(inf_yumi_o), 0);
    chk({tag, "_resp_v"}, 64'(resp_v_o), 0);
    chk({tag, "_resp_id"}, 64'(resp_id_o), 0);
    chk({tag, "_resp_iter"}, 64'(resp_iter_o), 0);
    chk({tag, "_resp_to"}, 64'(resp_timeout_o), 0);
  endtask

  task automatic randomize_pcs();
    for (int i = 0; i < NREQ; i++) req_pc[i*VA +: VA] = VA'({$urandom(), $urandom()});
  endtask

  // First requester at or after the priority pointer.
  function automatic int rr_pick(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return 0;
  endfunction

  // Called in an idle cycle; returns in the first discovery cycle.
  task automatic do_grant(input logic [NREQ-1:0] mask, input bit hold, output int id);
    logic [NREQ-1:0] eg;
    id = rr_pick(mask);
    eg = NREQ'(1 << id);
    req_v = mask;
    #1;
    chk("grant", 64'(grant_o), 64'(eg));
    exp_pc = req_pc[id*VA +: VA];
    m_ptr = (id + 1) % NREQ;
    tick();
    if (!hold) req_v = '0;
    chk("start_pulse", 64'(start_discovery_o), 1);
    chk("start_pc", 64'(striding_pc_o), 64'(exp_pc));
    chk("grant_in_start", 64'(grant_o), 0);
    tick();
    chk("start_low", 64'(start_discovery_o), 0);
  endtask

  // confirm_at/result_at are discovery-cycle indices (0 = first counting cycle), -1 = never.
  task automatic discover_resp(input int id, input int confirm_at, input int result_at,
                               input logic [7:0] iter, input int bp, input bit stale);
    bit         confirmed;
    bit         done;
    logic [7:0] e_iter;
    logic       e_to;
    confirmed = 1'b0;
    done      = 1'b0;
    e_iter    = '0;
    e_to      = 1'b0;
    for (int c = 0; c < TIMEOUT + 64 && !done; c++) begin
      req_confirm = NREQ'($urandom) & ~NREQ'(1 << id);
      if (c == confirm_at) req_confirm[id] = 1'b1;
      inf_v    = (c == result_at);
      inf_iter = (c == result_at) ? iter : 8'($urandom);
      randomize_pcs();
      #1;
      chk("disc_resp_v", 64'(resp_v_o), 0);
      chk("disc_confirm_o", 64'(confirm_discovery_o), 64'(confirmed));
      chk("disc_yumi", 64'(inf_yumi_o), 64'(inf_v));
      chk("disc_pc_stable", 64'(striding_pc_o), 64'(exp_pc));
      chk("disc_grant", 64'(grant_o), 0);
      if (c == result_at) begin
        done = 1'b1; e_iter = iter; e_to = 1'b0;
      end else if (c == confirm_at) begin
        confirmed = 1'b1;
      end else if (!confirmed && c == TIMEOUT - 1) begin
        done = 1'b1; e_iter = 8'(DEFITER); e_to = 1'b1;
      end
      tick();
      req_confirm = '0;
      inf_v       = 1'b0;
    end
    for (int k = 0; k <= bp; k++) begin
      resp_ready = (k == bp);
      inf_v      = stale && (k < bp) && (k % 2 == 1);
      inf_iter   = 8'($urandom);
      #1;
      chk("resp_v", 64'(resp_v_o), 1);
      chk("resp_id", 64'(resp_id_o), 64'(id));
      chk("resp_iter", 64'(resp_iter_o), 64'(e_iter));
      chk("resp_timeout", 64'(resp_timeout_o), 64'(e_to));
      chk("resp_grant", 64'(grant_o), 0);
      chk("resp_yumi", 64'(inf_yumi_o), 64'(inf_v));
      chk("resp_confirm_o", 64'(confirm_discovery_o), 0);
      tick();
    end
    resp_ready = 1'b0;
    inf_v      = 1'b0;
    chk("resp_released", 64'(resp_v_o), 0);
  endtask

  initial begin
    int              id;
    logic [NREQ-1:0] mask;
    int              ca;
    int              ra;
    reset_n     = 1'b0;
    req_v       = '0;
    req_pc      = '0;
    req_confirm = '0;
    inf_iter    = '0;
    inf_v       = 1'b0;
    resp_ready  = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();

    // Stale result while idle is consumed and produces nothing.
    inf_v    = 1'b1;
    inf_iter = 8'h55;
    #1;
    chk("stale_idle_yumi", 64'(inf_yumi_o), 1);
    chk("stale_idle_grant", 64'(grant_o), 0);
    tick();
    inf_v = 1'b0;
    chk("stale_idle_resp", 64'(resp_v_o), 0);

    // Fairness: all requests held, grants rotate 0,1,2,3,0.
    randomize_pcs();
    for (int n = 0; n < 5; n++) begin
      do_grant(4'hf, 1'b1, id);
      discover_resp(id, 0, 3, 8'(n + 10), 0, 1'b0);
    end
    req_v = '0;

    // Single request from entry 2.
    randomize_pcs();
    req_pc[2*VA +: VA] = VA'(39'h0_8000_0040);
    do_grant(4'b0100, 1'b0, id);
    chk("single_pc", 64'(striding_pc_o), 64'h8000_0040);
    discover_resp(id, 1, 3, 8'd37, 0, 1'b0);

    // Timeout with no confirm and no result.
    randomize_pcs();
    do_grant(4'b1000, 1'b0, id);
    discover_resp(id, -1, -1, 8'd0, 0, 1'b0);

    // Confirm lands on the final counting cycle and wins over the timeout.
    randomize_pcs();
    do_grant(4'b0010, 1'b0, id);
    discover_resp(id, TIMEOUT - 1, TIMEOUT + 5, 8'd5, 0, 1'b0);

    // Backpressure with stale results during the response, requests held.
    randomize_pcs();
    do_grant(4'b1111, 1'b1, id);
    discover_resp(id, -1, 4, 8'ha7, 10, 1'b1);
    req_v = '0;

    // Randomized transactions.
    for (int n = 0; n < 24; n++) begin
      randomize_pcs();
      mask = NREQ'($urandom_range(1, 15));
      ca   = int'($urandom_range(0, 12)) - 1;
      ra   = int'($urandom_range(0, 20));
      do_grant(mask, 1'($urandom), id);
      discover_resp(id, ca, ra, 8'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
      req_v = '0;
    end

    // Asynchronous reset in the middle of a confirmed discovery.
    randomize_pcs();
    do_grant(4'hf, 1'b1, id);
    req_confirm = NREQ'(1 << id);
    tick();
    req_confirm = '0;
    chk("pre_rst_confirmed", 64'(confirm_discovery_o), 1);
    #3 reset_n = 1'b0;
    inf_v = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #3 reset_n = 1'b1;
    inf_v = 1'b0;
    m_ptr = 0;
    tick();
    do_grant(4'hf, 1'b0, id);
    discover_resp(id, -1, 2, 8'h3c, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bp_be_loop_inference_sched.md
# bp_be_loop_inference_sched

Controller that shares a single loop-inference unit between `num_req_p` striding-load detector entries in the BE checker. It round-robin arbitrates discovery requests and sequences the unit through start, confirm and result handshakes. It enforces a discovery timeout and returns the remaining-iteration estimate, tagged with the requester ID, to the winning entry.

## Interface
Parameters:
- `bp_params_p`, `e_bp_default_cfg`: processor config; supplies `vaddr_width_p`.
- `num_req_p`, 4: number of requesting detector entries.
- `timeout_p`, 1024: maximum number of unconfirmed discovery cycles before abandoning.
- `output_range_p`, 8: width of the iteration estimate.
- `default_iter_p`, 128: estimate reported on timeout.

Ports:
- `clk_i`, in, 1: clock.
- `reset_n_i`, in, 1: reset, asynchronous and active-low.
- `req_v_i`, in, `num_req_p`: per-entry discovery request (level).
- `req_pc_i`, in, `num_req_p*vaddr_width_p`: per-entry striding-load PC.
- `req_confirm_i`, in, `num_req_p`: per-entry stride-confirmed pulse.
- `grant_o`, out, `num_req_p`: one-hot acceptance pulse.
- `start_discovery_o`, out, 1: to the inference unit.
- `confirm_discovery_o`, out, 1: to the inference unit.
- `striding_pc_o`, out, `vaddr_width_p`: to the inference unit.
- `inf_iter_i`, in, `output_range_p`: estimate from the unit.
- `inf_v_i`, in, 1: estimate valid.
- `inf_yumi_o`, out, 1: estimate consumed.
- `resp_v_o`, out, 1: response valid.
- `resp_id_o`, out, `$clog2(num_req_p)`: ID of the entry the response belongs to.
- `resp_iter_o`, out, `output_range_p`: iteration estimate.
- `resp_timeout_o`, out, 1: the estimate is the default value, not a measured value.
- `resp_ready_i`, in, 1: response consumer ready.

## Operation
- States:
  - `IDLE`: arbitrate among requests.
  - `START`: pulse `start_discovery_o`.
  - `DISCOVER`: count cycles, wait for confirm or result.
  - `CONFIRMED`: wait for result, no timeout.
  - `RESP`: hold the response.
- `IDLE`:
  - If any `req_v_i` is high, the round-robin winner is latched: ID, PC, and `grant_o[id]` is pulsed in the same cycle. Next state is `START`.
  - The priority pointer moves to `id+1` (mod `num_req_p`) after each grant.
- `START`:
  - `start_discovery_o` is high for exactly this one cycle.
  - The timeout counter is cleared. Next state is `DISCOVER`.
- `DISCOVER`:
  - The counter increments each cycle.
  - `req_confirm_i[id]` moves the block to `CONFIRMED`. Confirms from other entries are ignored.
  - If the counter reaches `timeout_p-1` with no confirm, the response is loaded with `default_iter_p` and `timeout=1`. Next state is `RESP`.
  - If confirm and timeout occur in the same cycle, confirm wins.
- `CONFIRMED`: `confirm_discovery_o` is held high.
- Result capture:
  - In `DISCOVER` or `CONFIRMED`, `inf_v_i` asserts `inf_yumi_o` combinationally in the same cycle.
  - The block captures `inf_iter_i` with `timeout=0`. Next state is `RESP`.
- Stale results: in `IDLE`, `START` or `RESP`, an asserted `inf_v_i` is also yumi'd and discarded.
- `RESP`:
  - `resp_v_o` is held high and the response fields are held stable until `resp_ready_i`.
  - Next state is `IDLE`. No grant is issued in the `RESP` exit cycle.
- `striding_pc_o` holds the latched PC from grant until the next grant. It never changes mid-discovery.
- A requester that drops `req_v_i` after its grant does not abort the sequence.

## Timing
- Reset value of every output is 0. Reset also sets state to `IDLE`, the priority pointer to 0, and the counter to 0.
- Reset asserted mid-sequence abandons the sequence with no response. The inference unit shares this reset domain.
- The grant cycle is T. `start_discovery_o` is high in cycle T+1. Counting begins at T+2.
- The timeout response appears at T+2+`timeout_p` when no confirm arrives.
- From an `inf_v_i` handshake in cycle C, `resp_v_o` is high in cycle C+1.
- Minimum spacing between grants is 4 cycles.
- Counter width is `$clog2(timeout_p)`. It never wraps, because it stops on leaving `DISCOVER`.

## Structure
- Shared package `bp_be_pkg` holds the `bp_be_loop_sched_state_e` enum and the response struct `bp_be_loop_sched_resp_s` {id, iter, timeout}.
- The round-robin arbiter is instantiated as `bsg_arb_round_robin`, which is the natural single sub-module.
- The FSM, counter and response register stay local to this block.

## Test plan
- Single request: `req_v_i=4'b0100`, PC `0x8000_0040` -> `grant_o=0100` at T, `start_discovery_o` at T+1, `striding_pc_o=0x8000_0040`. Then confirm, then `inf_v_i` with iter `37` -> `resp_id=2`, `resp_iter=37`, `resp_timeout=0`.
- Fairness: all four requests held continuously -> grants issued in order 0,1,2,3,0, each only after the previous response handshake.
- Timeout: grant with no confirm and no `inf_v_i` -> `resp_v_o` at T+2+1024 with `iter=128` and `resp_timeout=1`.
- Confirm on the timeout cycle: `req_confirm_i[id]` coincident with counter=1023 -> enter `CONFIRMED`, no timeout response. A later `inf_v_i` with iter `5` -> `resp_iter=5`.
- Backpressure and stale results: `resp_ready_i=0` for 10 cycles with `inf_v_i` pulsed during `RESP` -> response held unchanged, stale result yumi'd, no new grant until ready.
- Async reset mid-`CONFIRMED`: `reset_n_i` low between clock edges -> all outputs go to 0 immediately, and after release the first grant goes to entry 0.
